// File: rtl/fp_mul_arbiter_if.sv
// ============================================================================
//  Module      : fp_mul_arbiter_if
//  Description : Requester, multiplier-core and response bundle shared by
//                fp_mul_arbiter and its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_mul_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           mul_a;
    logic [31:0]           mul_b;
    logic [31:0]           mul_result;
    logic                  mul_overflow;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_result;
    logic                  rsp_overflow;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;
    logic [15:0]           ovf_count;

    // Environment side: requesters, multiplier core and response consumer.
    modport master (
        output req_valid, req_a, req_b, mul_result, mul_overflow, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_result, rsp_overflow,
               rsp_id, busy, ovf_count
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_result, mul_overflow, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_result, rsp_overflow,
               rsp_id, busy, ovf_count
    );
endinterface

`default_nettype wire

// File: rtl/fp_mul_arbiter.sv
// ============================================================================
//  Module      : fp_mul_arbiter
//  Description : Round-robin arbiter sharing one external single-precision
//                multiplier core between NUM_REQ requesters, one op in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fp_mul_arbiter_if.slave    bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MUL_LAT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [ID_W-1:0]  C_LAST_RST = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      res_q, res_d;
    logic             res_ovf_q, res_ovf_d;
    logic [15:0]      ovf_count_q, ovf_count_d;

    logic             w_any_valid;
    logic             w_accept;
    logic             w_handshake;
    logic [ID_W-1:0]  w_grant;

    assign w_any_valid = |bus.req_valid;
    assign w_accept    = (state_q == S_IDLE) && w_any_valid;
    assign w_handshake = (state_q == S_RESP) && bus.rsp_ready;

    // Search begins one past the previous winner so every requester gets a turn.
    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        int              sum;
        found   = 1'b0;
        idx     = '0;
        sum     = 0;
        w_grant = last_grant_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = int'(last_grant_q) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = ID_W'(sum);
            if (!found && bus.req_valid[idx]) begin
                found   = 1'b1;
                w_grant = idx;
            end
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (w_any_valid)        state_d = S_EXEC;
            S_EXEC: if (cnt_q == C_CNT_ONE) state_d = S_RESP;
            S_RESP: if (bus.rsp_ready)      state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = w_accept && (w_grant == ID_W'(i));
        end
        bus.rsp_valid = (state_q == S_RESP);
        bus.busy      = (state_q != S_IDLE);
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        res_ovf_d    = res_ovf_q;
        ovf_count_d  = ovf_count_q;

        if (w_accept) begin
            last_grant_d = w_grant;
            id_d         = w_grant;
            cnt_d        = C_CNT_LOAD;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant == ID_W'(i)) begin
                    op_a_d = bus.req_a[i*32 +: 32];
                    op_b_d = bus.req_b[i*32 +: 32];
                end
            end
        end

        if (state_q == S_EXEC) begin
            cnt_d = cnt_q - C_CNT_ONE;
            if (cnt_q == C_CNT_ONE) begin
                res_d     = bus.mul_result;
                res_ovf_d = bus.mul_overflow;
            end
        end

        // Saturates rather than wrapping so a long run never hides overflows.
        if (w_handshake && res_ovf_q && (ovf_count_q != 16'hFFFF)) begin
            ovf_count_d = ovf_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= C_LAST_RST;
            id_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            cnt_q        <= '0;
            res_q        <= '0;
            res_ovf_q    <= 1'b0;
            ovf_count_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            cnt_q        <= cnt_d;
            res_q        <= res_d;
            res_ovf_q    <= res_ovf_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign bus.mul_a        = op_a_q;
    assign bus.mul_b        = op_b_q;
    assign bus.rsp_result   = res_q;
    assign bus.rsp_overflow = res_ovf_q;
    assign bus.rsp_id       = id_q;
    assign bus.ovf_count    = ovf_count_q;

endmodule

`default_nettype wire
